imem_load_ctrl: RTL
===================

# imem_load_ctrl

Sequencer that owns the address/write port of the 128 x 24-bit instruction RAM. In run mode it passes the CPU fetch address through to the RAM. In load mode it holds the uniciclo CPU, takes a byte stream over a valid/ready handshake, packs it into 24-bit instruction words and writes them into consecutive RAM locations from word 0. When the load finishes it releases the CPU with a restart pulse, so programs change without resynthesis.

## Interface
Parameters:
- DEPTH, 128, number of instruction words; index width AW = $clog2(DEPTH) = 7
- WORD, 24, instruction width; always 3 bytes

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle request to begin a load
- load_len  in  8  words to load, sampled with load_start
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  controller accepts a byte this cycle
- cpu_addr  in  24  CPU byte fetch address (word aligned)
- mem_addr  out  AW  RAM word index
- mem_wdata  out  WORD  RAM write data
- mem_we  out  1  RAM write enable
- cpu_hold  out  1  CPU stall (PC and register writes frozen)
- cpu_restart  out  1  one-cycle pulse forcing the CPU PC to 0
- load_busy  out  1  high while loading
- load_done  out  1  one-cycle pulse when the last word is written
- words_loaded  out  8  words written in the current or last load

## Operation
- FSM states: RUN, B0, B1, B2, WR, DONE.
- RUN:
  - mem_addr = cpu_addr[AW+1:2]; mem_we = 0; cpu_hold = 0; rx_ready = 0.
  - On load_start:
    - If load_len == 0, go to DONE with no writes.
    - Otherwise latch len = min(load_len, DEPTH), clear the word index and words_loaded, and go to B0.
- B0, B1, B2:
  - rx_ready = 1; cpu_hold = 1.
  - A byte is accepted only when rx_valid && rx_ready, and the state advances only on acceptance.
  - Byte order is MSB first: B0 fills [23:16], B1 fills [15:8], B2 fills [7:0], then go to WR.
- WR:
  - mem_addr = word index; mem_wdata = assembled word; mem_we = 1 for exactly one cycle.
  - Increment the word index and words_loaded.
  - If the new count == len, go to DONE; otherwise go to B0.
- DONE:
  - load_done = 1 and cpu_restart = 1 for one cycle; cpu_hold is still 1 in this cycle.
  - Go to RUN.
- load_busy = 1 in B0, B1, B2, WR and DONE.
- load_start is ignored outside RUN.
- Bytes beyond len are never accepted, because rx_ready is 0 in RUN.
- load_len > 128 saturates to 128. The index cannot wrap: the last write is index 127.
- RAM words not rewritten keep their old contents.
- A stalled stream (rx_valid = 0) waits indefinitely in a byte state. There is no timeout.

## Timing
- Reset values:
  - State RUN; index, words_loaded and the assembly register are 0.
  - mem_we = 0, rx_ready = 0, cpu_hold = 0, cpu_restart = 0, load_busy = 0, load_done = 0.
  - mem_addr follows cpu_addr.
- Reset during a load:
  - Returns to RUN in the next cycle with no further writes; any partial word is discarded.
  - Words already written stay in RAM.
  - No cpu_restart is generated. The CPU receives reset directly.
- Timing from load_start sampled in cycle T (load_len > 0):
  - B0 is entered at T+1, with cpu_hold and rx_ready high from T+1.
  - With rx_valid held high, each word takes 4 cycles (3 byte cycles + WR).
  - N words finish with DONE at T + 4N + 1.
  - RUN is restored, and cpu_hold falls, at T + 4N + 2.
- With load_len == 0 sampled at T: DONE at T+1, RUN at T+2.
- The write is synchronous: the RAM captures mem_wdata at the clk edge ending the WR cycle.
- CPU reads remain combinational through mem_addr in RUN.
- Outputs are combinational from the state register. mem_wdata is registered.

## Test plan
- Reset then RUN: cpu_addr = 0x000014 -> mem_addr = 5; mem_we = 0; cpu_hold = 0.
- Load two words, load_len = 2, bytes E6,80,88,E3,08,10 back-to-back:
  - RAM[0] = 0xE68088 and RAM[1] = 0xE30810.
  - mem_we pulses at T+4 and T+8; load_done at T+9; cpu_hold falls at T+10; words_loaded = 2.
- Stream gaps: rx_valid toggled 1/0 during a one-word load -> same word written; mem_we fires only after the third accepted byte.
- Saturation: load_len = 200 with 128 words streamed -> last write at index 127; rx_ready = 0 afterwards; a 129th byte is not consumed.
- Reset mid-load: reset asserted in B1 of word 3 -> RUN next cycle; RAM[0..1] updated, RAM[2] unchanged; cpu_restart never pulses.
- load_start asserted again while in B2 -> ignored; the load completes with the original len.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction RAM port sequencer: passes CPU fetch addresses through in run mode,
// and in load mode packs a byte stream into 24-bit words written from index 0.
module imem_load_ctrl #(
  parameter int DEPTH = 128,
  parameter int WORD  = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_start,
  input  logic [7:0]      load_len,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic [23:0]     cpu_addr,
  output logic [AW-1:0]   mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            mem_we,
  output logic            cpu_hold,
  output logic            cpu_restart,
  output logic            load_busy,
  output logic            load_done,
  output logic [7:0]      words_loaded
);

  typedef enum logic [2:0] {RUN, B0, B1, B2, WR, DONE} state_t;

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q;
  logic [7:0]      cnt_q;
  logic [7:0]      len_q;
  logic [WORD-1:0] word_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset clears the partial word so an aborted load leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        RUN: begin
          if (load_start && load_len != 8'd0) begin
            len_q <= (load_len > DEPTH_L) ? DEPTH_L : load_len;
            idx_q <= '0;
            cnt_q <= '0;
          end
        end
        B0: if (rx_valid) word_q[WORD-1 -: 8] <= rx_data;
        B1: if (rx_valid) word_q[WORD-9 -: 8] <= rx_data;
        B2: if (rx_valid) word_q[7:0]         <= rx_data;
        WR: begin
          idx_q <= idx_q + 1'b1;
          cnt_q <= cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and state_d gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    mem_addr    = cpu_addr[AW+1:2];
    mem_we      = 1'b0;
    rx_ready    = 1'b0;
    cpu_hold    = 1'b0;
    cpu_restart = 1'b0;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      RUN: begin
        if (load_start) state_d = (load_len == 8'd0) ? DONE : B0;
      end
      B0, B1, B2: begin
        rx_ready  = 1'b1;
        cpu_hold  = 1'b1;
        load_busy = 1'b1;
        if (rx_valid) begin
          case (state_q)
            B0:      state_d = B1;
            B1:      state_d = B2;
            default: state_d = WR;
          endcase
        end
      end
      WR: begin
        mem_addr  = idx_q;
        mem_we    = 1'b1;
        cpu_hold  = 1'b1;
        load_busy = 1'b1;
        state_d   = (cnt_q + 8'd1 == len_q) ? DONE : B0;
      end
      DONE: begin
        cpu_hold    = 1'b1;
        load_busy   = 1'b1;
        load_done   = 1'b1;
        cpu_restart = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign mem_wdata    = word_q;
  assign words_loaded = cnt_q;

endmodule
